// File: rtl/windowed_threshold_integrator.sv
// Windowed threshold integrator.
// Each channel adds its held signed sample into a chunk accumulator every RUNNING cycle.
// Completed chunks go into a per-channel ring of 2^DEPTH_LOG2 entries. A running window
// total is kept alongside the ring. A channel trips when |total| > threshold << (c+DEPTH_LOG2),
// where c is the chunk_log2 value latched when the block leaves IDLE.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   enable          run request; low returns to IDLE unless tripped
//   chunk_log2      chunk length exponent, sampled on leaving IDLE
//   threshold       unsigned average-magnitude limit
//   value_in        packed offset-binary samples, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   value_valid     per-channel sample strobe
//   setup_done      high once CLEAR has finished (holds in TRIPPED)
//   window_full     high once the ring has been filled once
//   over_threshold  sticky trip flag
//   over_channel    sticky per-channel trip bits
//   config_error    sticky, chunk_log2 was out of range
//   peak_total      (only with WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN) per-channel max |total|
module windowed_threshold_integrator #(
  parameter int unsigned CHANNELS       = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter int unsigned MAX_CHUNK_LOG2 = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [4:0]                     chunk_log2,
  input  logic [DATA_WIDTH-2:0]          threshold,
  input  logic [CHANNELS*DATA_WIDTH-1:0] value_in,
  input  logic [CHANNELS-1:0]            value_valid,
  output logic                           setup_done,
  output logic                           window_full,
  output logic                           over_threshold,
  output logic [CHANNELS-1:0]            over_channel,
`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
  output logic [CHANNELS*(DATA_WIDTH+MAX_CHUNK_LOG2+DEPTH_LOG2)-1:0] peak_total,
`endif
  output logic                           config_error
);

  localparam int unsigned AW   = DATA_WIDTH + MAX_CHUNK_LOG2;
  localparam int unsigned TW   = AW + DEPTH_LOG2;
  localparam int unsigned RING = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StClear, StRunning, StTripped} state_e;

  state_e                    r_state, w_state_next;
  logic [4:0]                r_c;
  logic [TW-1:0]             r_limit;
  logic [MAX_CHUNK_LOG2-1:0] r_cnt, w_mask;
  logic [DEPTH_LOG2-1:0]     r_ptr;
  logic                      r_push;
  logic                      r_setup_done, r_window_full, r_over_threshold, r_config_error;
  logic [CHANNELS-1:0]       r_over_channel, w_over;
  logic                      w_wrap, w_cfg_bad, w_abort;
  logic [5:0]                w_shamt;

  logic signed [DATA_WIDTH-1:0] r_held      [CHANNELS];
  logic signed [AW-1:0]         r_acc       [CHANNELS];
  logic signed [AW-1:0]         r_chunk     [CHANNELS];
  logic signed [AW-1:0]         w_held_ext  [CHANNELS];
  logic signed [TW-1:0]         r_total     [CHANNELS];
  logic signed [TW-1:0]         w_chunk_ext [CHANNELS];
  logic signed [TW-1:0]         w_evict_ext [CHANNELS];
  logic signed [AW-1:0]         r_ring      [CHANNELS][RING];
  // One extra bit so |most-negative total| does not wrap.
  logic [TW:0]                  w_ext       [CHANNELS];
  logic [TW:0]                  w_abs       [CHANNELS];
`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
  logic [TW-1:0]                r_peak      [CHANNELS];
`endif

  assign w_cfg_bad = (chunk_log2 == 5'd0) || ({27'd0, chunk_log2} > MAX_CHUNK_LOG2);
  assign w_shamt   = {1'b0, chunk_log2} + 6'(DEPTH_LOG2);
  assign w_mask    = ~({MAX_CHUNK_LOG2{1'b1}} << r_c);
  assign w_wrap    = (r_cnt == w_mask);
  assign w_abort   = !enable && ((r_state == StClear) || (r_state == StRunning));

  assign setup_done     = r_setup_done;
  assign window_full    = r_window_full;
  assign over_threshold = r_over_threshold;
  assign over_channel   = r_over_channel;
  assign config_error   = r_config_error;

  always_comb begin
    w_over = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_held_ext[i]  = {{(AW-DATA_WIDTH){r_held[i][DATA_WIDTH-1]}}, r_held[i]};
      w_chunk_ext[i] = {{DEPTH_LOG2{r_chunk[i][AW-1]}}, r_chunk[i]};
      w_evict_ext[i] = {{DEPTH_LOG2{r_ring[i][r_ptr][AW-1]}}, r_ring[i][r_ptr]};
      w_ext[i]       = {r_total[i][TW-1], r_total[i]};
      w_abs[i]       = w_ext[i][TW] ? ((~w_ext[i]) + {{TW{1'b0}}, 1'b1}) : w_ext[i];
      w_over[i]      = (r_state == StRunning) && enable && (w_abs[i] > {1'b0, r_limit});
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (enable) w_state_next = w_cfg_bad ? StTripped : StClear;
      StClear:   if (!enable) w_state_next = StIdle;
                 else if (&r_ptr) w_state_next = StRunning;
      StRunning: if (!enable) w_state_next = StIdle;
                 else if (|w_over) w_state_next = StTripped;
      StTripped: w_state_next = StTripped;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c              <= '0;
      r_limit          <= '0;
      r_cnt            <= '0;
      r_ptr            <= '0;
      r_push           <= 1'b0;
      r_setup_done     <= 1'b0;
      r_window_full    <= 1'b0;
      r_over_threshold <= 1'b0;
      r_over_channel   <= '0;
      r_config_error   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_held[i]  <= '0;
        r_acc[i]   <= '0;
        r_chunk[i] <= '0;
        r_total[i] <= '0;
`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
        r_peak[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (value_valid[i]) begin
          r_held[i] <= {~value_in[i*DATA_WIDTH+DATA_WIDTH-1],
                        value_in[i*DATA_WIDTH +: DATA_WIDTH-1]};
        end
      end
      if (w_abort) begin
        r_cnt         <= '0;
        r_ptr         <= '0;
        r_push        <= 1'b0;
        r_setup_done  <= 1'b0;
        r_window_full <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
          r_acc[i]   <= '0;
          r_chunk[i] <= '0;
          r_total[i] <= '0;
        end
      end else begin
        unique case (r_state)
          StIdle: begin
            if (enable) begin
              if (w_cfg_bad) begin
                r_config_error   <= 1'b1;
                r_over_threshold <= 1'b1;
              end else begin
                r_c     <= chunk_log2;
                r_limit <= {{(TW-DATA_WIDTH+1){1'b0}}, threshold} << w_shamt;
              end
            end
          end
          StClear: begin
            // r_ptr doubles as the ring clear index; it wraps back to 0 on exit.
            r_ptr  <= r_ptr + DEPTH_LOG2'(1);
            r_cnt  <= '0;
            r_push <= 1'b0;
            if (&r_ptr) r_setup_done <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
              r_acc[i]   <= '0;
              r_chunk[i] <= '0;
              r_total[i] <= '0;
`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
              r_peak[i]  <= '0;
`endif
            end
          end
          StRunning: begin
            r_cnt  <= w_wrap ? '0 : r_cnt + MAX_CHUNK_LOG2'(1);
            r_push <= w_wrap;
            if (r_push) begin
              r_ptr <= r_ptr + DEPTH_LOG2'(1);
              if (&r_ptr) r_window_full <= 1'b1;
            end
            r_over_channel <= r_over_channel | w_over;
            if (|w_over) r_over_threshold <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
              if (w_wrap) begin
                r_chunk[i] <= r_acc[i] + w_held_ext[i];
                r_acc[i]   <= '0;
              end else begin
                r_acc[i]   <= r_acc[i] + w_held_ext[i];
              end
              if (r_push) r_total[i] <= r_total[i] + w_chunk_ext[i] - w_evict_ext[i];
`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
              if (w_abs[i][TW-1:0] > r_peak[i]) r_peak[i] <= w_abs[i][TW-1:0];
`endif
            end
          end
          StTripped: begin
          end
        endcase
      end
    end
  end

  // Ring storage needs no reset: CLEAR zeroes every entry before it is read.
  always_ff @(posedge clk) begin
    if (!reset && !w_abort) begin
      if (r_state == StClear) begin
        for (int i = 0; i < CHANNELS; i++) r_ring[i][r_ptr] <= '0;
      end else if ((r_state == StRunning) && r_push) begin
        for (int i = 0; i < CHANNELS; i++) r_ring[i][r_ptr] <= r_chunk[i];
      end
    end
  end

`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
  always_comb begin
    peak_total = '0;
    for (int i = 0; i < CHANNELS; i++) peak_total[i*TW +: TW] = r_peak[i];
  end
`endif

endmodule

// File: tb/tb_windowed_threshold_integrator.sv
// Self-checking bench for windowed_threshold_integrator.
// Runs use chunk_log2=2 and threshold=100, giving a limit of 6400.
// Edge numbering: e0 is the first clock edge with enable sampled high.
// CLEAR ends at e16. Chunk k closes at e(16+4k) and is pushed at e(17+4k).
// Its compare result is registered at e(18+4k).
module tb_windowed_threshold_integrator;
  localparam int CH = 8;
  localparam int DW = 16;
  localparam int TW = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [4:0]    chunk_log2;
  logic [DW-2:0] threshold;
  logic [CH*DW-1:0] value_in;
  logic [CH-1:0] value_valid;
  logic          setup_done, window_full, over_threshold, config_error;
  logic [CH-1:0] over_channel;
`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
  logic [CH*TW-1:0] peak_total;
`endif

  always #5 clk = ~clk;

  windowed_threshold_integrator dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .chunk_log2     (chunk_log2),
    .threshold      (threshold),
    .value_in       (value_in),
    .value_valid    (value_valid),
    .setup_done     (setup_done),
    .window_full    (window_full),
    .over_threshold (over_threshold),
    .over_channel   (over_channel),
`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
    .peak_total     (peak_total),
`endif
    .config_error   (config_error)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string  tag;
    longint val;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input longint val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop_cmp(input longint got);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", got, -12345);
    end else begin
      e = sb.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int v);
    logic [31:0] raw;
    raw = v + 32'h8000;
    value_in[ch*DW +: DW] = raw[DW-1:0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_setup_done"}, setup_done, 0);
    chk({tag, "_window_full"}, window_full, 0);
    chk({tag, "_over_threshold"}, over_threshold, 0);
    chk({tag, "_over_channel"}, over_channel, 0);
    chk({tag, "_config_error"}, config_error, 0);
  endtask

  // Expected outcome of one enabled run, queued as the run is launched.
  task automatic expect_run(input int sd, input int wf, input int tr, input int oc, input int ot);
    sb_push("setup_edge", sd);
    sb_push("full_edge", wf);
    sb_push("trip_edge", tr);
    sb_push("over_channel", oc);
    sb_push("over_threshold", ot);
  endtask

  // Watches a bounded number of edges; a missing event records -1.
  task automatic run_watch(input int budget, input bit alt_ch1);
    int sd_e, wf_e, tr_e;
    bit pos;
    sd_e = -1;
    wf_e = -1;
    tr_e = -1;
    pos  = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (alt_ch1 && (n % 4 == 0)) begin
        pos = ~pos;
        set_ch(1, pos ? 1000 : -1000);
      end
      tick(1);
      if (setup_done && sd_e < 0) sd_e = n;
      if (window_full && wf_e < 0) wf_e = n;
      if (over_threshold && tr_e < 0) tr_e = n;
    end
    sb_pop_cmp(sd_e);
    sb_pop_cmp(wf_e);
    sb_pop_cmp(tr_e);
    sb_pop_cmp(over_channel);
    sb_pop_cmp(over_threshold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    chunk_log2  = 5'd2;
    threshold   = 15'd100;
    value_in    = {CH{16'h8000}};
    value_valid = '1;
    tick(2);
    reset = 1'b0;
    chk_all_zero("reset");

    // Ch0 at +99/cycle settles at 6336, below 6400.
    set_ch(0, 99);
    enable = 1'b1;
    expect_run(16, 81, -1, 8'h00, 0);
    run_watch(500, 1'b0);
`ifdef WINDOWED_THRESHOLD_INTEGRATOR_PEAK_EN
    chk("peak_ch0", peak_total[TW-1:0], 6336);
`endif
    enable = 1'b0;
    tick(1);
    chk("drop_setup_done", setup_done, 0);
    chk("drop_window_full", window_full, 0);
    // A stale 6336 total would trip on the first push after re-enable.
    enable = 1'b1;
    expect_run(16, 81, -1, 8'h00, 0);
    run_watch(300, 1'b0);
    enable = 1'b0;
    tick(1);
    set_ch(0, 0);

    // Ch1 alternating +-1000 per chunk never exceeds 4000.
    enable = 1'b1;
    expect_run(16, 81, -1, 8'h00, 0);
    run_watch(1000, 1'b1);
    enable = 1'b0;
    tick(1);
    set_ch(1, 0);
    chk("alt_over_threshold", over_threshold, 0);

    // Ch3 at +101: chunk 15 gives 6060 (no trip), chunk 16 gives 6464.
    set_ch(3, 101);
    enable = 1'b1;
    expect_run(16, 81, 82, 8'h08, 1);
    run_watch(120, 1'b0);
    enable = 1'b0;
    tick(2);
    chk("tripped_hold_ot", over_threshold, 1);
    chk("tripped_hold_sd", setup_done, 1);
    do_reset();
    chk_all_zero("reset_after_trip");
    set_ch(3, 0);

    // Ch5 at -101 trips through the negative magnitude path.
    set_ch(5, -101);
    enable = 1'b1;
    expect_run(16, 81, 82, 8'h20, 1);
    run_watch(120, 1'b0);
    enable = 1'b0;
    do_reset();

    // Two channels tripping in the same cycle.
    set_ch(3, 101);
    enable = 1'b1;
    expect_run(16, 81, 82, 8'h28, 1);
    run_watch(120, 1'b0);
    enable = 1'b0;
    do_reset();
    set_ch(5, 0);

    // Reset mid-fill, enable held: the full trip latency must repeat.
    enable = 1'b1;
    expect_run(16, -1, -1, 8'h00, 0);
    run_watch(50, 1'b0);
    do_reset();
    chk_all_zero("reset_mid_fill");
    expect_run(16, 81, 82, 8'h08, 1);
    run_watch(120, 1'b0);
    enable = 1'b0;
    do_reset();
    set_ch(3, 0);

    // Out-of-range chunk_log2 values.
    chunk_log2 = 5'd0;
    enable = 1'b1;
    tick(1);
    chk("cfg0_config_error", config_error, 1);
    chk("cfg0_over_threshold", over_threshold, 1);
    chk("cfg0_over_channel", over_channel, 0);
    enable = 1'b0;
    do_reset();
    chk("cfg0_reset_ce", config_error, 0);
    chk("cfg0_reset_ot", over_threshold, 0);
    chunk_log2 = 5'd21;
    enable = 1'b1;
    tick(1);
    chk("cfg21_config_error", config_error, 1);
    chk("cfg21_over_threshold", over_threshold, 1);
    chk("cfg21_setup_done", setup_done, 0);
    enable = 1'b0;
    do_reset();
    chk("cfg21_reset_ce", config_error, 0);
    chk("cfg21_reset_ot", over_threshold, 0);

    chk("sb_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
